popcount_stream: RTL and testbench

POPCOUNT_STREAM -- requirements
Module: popcount_stream

---
 rtl/popcount_pkg.sv | 48 ++++
 rtl/popcount_tree_level.sv | 48 ++++
 rtl/popcount_stream.sv | 181 ++++++++++++++++++
 tb/tb_popcount_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared sizing helpers for the streaming popcount block.
// - calc_wa     : word width after zero padding (power of two, at least 4)
// - calc_levels : number of registered adder-tree levels above the 4-bit leaves
// - calc_lat    : accept-to-output latency in cycles
// - calc_out_w  : width of the data_o port
// - level_w     : width of one partial count at tree level k (level 0 = leaves)
// - level_off   : bit offset of level k inside the flattened tree bus
// - count4      : ones count of a 4-bit nibble
package popcount_pkg;

    function automatic int calc_wa(input int width);
        int p;
        p = 1 << $clog2(width);
        return (p < 4) ? 4 : p;
    endfunction

    function automatic int calc_levels(input int width);
        return $clog2(calc_wa(width)) - 2;
    endfunction

    function automatic int calc_lat(input int width);
        return calc_levels(width) + 2;
    endfunction

    function automatic int calc_out_w(input int width, input int accumulate, input int acc_w);
        return (accumulate != 0) ? acc_w : $clog2(width + 1);
    endfunction

    // A level-k sum covers 2**(k+2) input bits, so it needs exactly this many bits.
    function automatic int level_w(input int k);
        return $clog2((1 << (k + 2)) + 1);
    endfunction

    // Level j holds wa/2**(j+2) partial counts of level_w(j) bits each.
    function automatic int level_off(input int wa, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) begin
            off += (wa >> (j + 2)) * level_w(j);
        end
        return off;
    endfunction

    function automatic logic [2:0] count4(input logic [3:0] nib);
        return {2'b00, nib[0]} + {2'b00, nib[1]} + {2'b00, nib[2]} + {2'b00, nib[3]};
    endfunction

endpackage

// File: rtl/popcount_tree_level.sv
// One registered level of the popcount adder tree: adds neighbouring pairs of
// partial counts and registers the results together with valid and last flags.
// Ports:
//   clk_i, arst_ni     clock, asynchronous active-low reset (clears vld only)
//   en                 global pipeline enable; level holds when low
//   src_vld, src_last  flags of the level below
//   src_sum            N_IN packed partial counts of IN_W bits
//   vld, last          registered flags
//   sum                N_IN/2 packed partial counts of IN_W+1 bits
module popcount_tree_level
    import popcount_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int IN_W = 3
) (
    input  logic                            clk_i,
    input  logic                            arst_ni,
    input  logic                            en,
    input  logic                            src_vld,
    input  logic                            src_last,
    input  logic [N_IN*IN_W-1:0]            src_sum,
    output logic                            vld,
    output logic                            last,
    output logic [(N_IN/2)*(IN_W+1)-1:0]    sum
);

    localparam int N_OUT = N_IN / 2;
    localparam int SUM_W = IN_W + 1;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            vld <= 1'b0;
        end else if (en) begin
            vld <= src_vld;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            last <= src_last;
            for (int i = 0; i < N_OUT; i++) begin
                sum[i*SUM_W +: SUM_W] <= SUM_W'(src_sum[(2*i)*IN_W +: IN_W])
                                       + SUM_W'(src_sum[(2*i+1)*IN_W +: IN_W]);
            end
        end
    end

endmodule

// File: rtl/popcount_stream.sv
// Streaming population count with valid/ready handshakes on both sides.
// Each accepted word is padded to a power of two, split into 4-bit leaves and
// reduced by a registered binary adder tree. With ACCUMULATE=0 every word
// yields its own count; with ACCUMULATE=1 counts are summed per frame
// (terminated by data_last_i) into a saturating ACC_W-bit accumulator.
// Ports:
//   clk_i, arst_ni   clock, asynchronous active-low reset
//   data_i           input word (WIDTH bits)
//   data_val_i       input word valid
//   data_last_i      last word of a frame (frame mode only)
//   cnt_zeros_i      count zero bits instead of one bits
//   data_ready_o     input word accepted this cycle when data_val_i is high
//   data_o           count / frame sum (OUT_W bits)
//   data_sat_o       frame sum saturated
//   data_val_o       data_o valid
//   data_ready_i     downstream accepts data_o
module popcount_stream
    import popcount_pkg::*;
#(
    parameter  int WIDTH      = 24,
    parameter  int ACCUMULATE = 0,
    parameter  int ACC_W      = 16,
    localparam int OUT_W      = calc_out_w(WIDTH, ACCUMULATE, ACC_W)
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    input  logic             data_last_i,
    input  logic             cnt_zeros_i,
    output logic             data_ready_o,
    output logic [OUT_W-1:0] data_o,
    output logic             data_sat_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    localparam int WA     = calc_wa(WIDTH);
    localparam int LEVELS = calc_levels(WIDTH);
    localparam int N_LEAF = WA / 4;
    localparam int LEAF_W = level_w(0);
    localparam int CW     = level_w(LEVELS);
    localparam int BUS_W  = level_off(WA, LEVELS + 1);

    // The whole pipeline advances together; it only stalls when a result is
    // waiting and downstream refuses it.
    logic en;
    assign en           = !data_val_o || data_ready_i;
    assign data_ready_o = en;

    // Inversion touches only the real bits; the zero extension supplies pad
    // bits that can never contribute to the count.
    logic [WA-1:0] word;
    assign word = WA'(data_i ^ {WIDTH{cnt_zeros_i}});

    // Stage 0: 4-bit leaf counts
    logic [N_LEAF*LEAF_W-1:0] leaf_p0;
    logic                     vld_p0;
    logic                     last_p0;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            vld_p0 <= 1'b0;
        end else if (en) begin
            vld_p0 <= data_val_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            last_p0 <= data_last_i;
            for (int i = 0; i < N_LEAF; i++) begin
                leaf_p0[i*LEAF_W +: LEAF_W] <= count4(word[i*4 +: 4]);
            end
        end
    end

    // Adder-tree levels 1..LEVELS, each stored in its own slice of tree_bus
    logic [BUS_W-1:0]  tree_bus;
    logic [LEVELS:0]   tree_vld;
    logic [LEVELS:0]   tree_last;

    assign tree_bus[0 +: N_LEAF*LEAF_W] = leaf_p0;
    assign tree_vld[0]                  = vld_p0;
    assign tree_last[0]                 = last_p0;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N_IN    = WA >> (k + 1);
        localparam int IN_W    = level_w(k - 1);
        localparam int SRC_OFF = level_off(WA, k - 1);
        localparam int DST_OFF = level_off(WA, k);

        popcount_tree_level #(
            .N_IN (N_IN),
            .IN_W (IN_W)
        ) u_level (
            .clk_i    (clk_i),
            .arst_ni  (arst_ni),
            .en       (en),
            .src_vld  (tree_vld[k-1]),
            .src_last (tree_last[k-1]),
            .src_sum  (tree_bus[SRC_OFF +: N_IN*IN_W]),
            .vld      (tree_vld[k]),
            .last     (tree_last[k]),
            .sum      (tree_bus[DST_OFF +: (N_IN/2)*(IN_W+1)])
        );
    end

    logic [CW-1:0] cnt_t;
    logic          vld_t;
    logic          end_word;

    assign cnt_t    = tree_bus[level_off(WA, LEVELS) +: CW];
    assign vld_t    = tree_vld[LEVELS];
    // Word whose arrival at the final stage produces a visible result
    assign end_word = vld_t && (ACCUMULATE == 0 || tree_last[LEVELS]);

    // Final stage: output register (per-word) or accumulator (per-frame)
    if (ACCUMULATE == 0) begin : g_word
        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                data_val_o <= 1'b0;
                data_o     <= '0;
            end else if (en) begin
                data_val_o <= end_word;
                if (end_word) begin
                    data_o <= OUT_W'(cnt_t);
                end
            end
        end

        assign data_sat_o = 1'b0;
    end else begin : g_frame
        localparam int SUM_W = ((ACC_W > CW) ? ACC_W : CW) + 1;

        logic [ACC_W-1:0] acc;
        logic             acc_sat;
        logic [ACC_W-1:0] base_acc;
        logic             base_sat;
        logic [SUM_W-1:0] sum_wide;
        logic [ACC_W-1:0] sum_sat;
        logic             sat_next;

        always_comb begin
            // While a frame result is on the output, any enabled cycle is its
            // handshake, so the incoming word starts a fresh frame from zero.
            base_acc = data_val_o ? '0 : acc;
            base_sat = data_val_o ? 1'b0 : acc_sat;
            sum_wide = SUM_W'(base_acc) + SUM_W'(cnt_t);
            // Flag stays sticky so later words cannot hide an earlier overflow.
            sat_next = base_sat || (sum_wide > SUM_W'({ACC_W{1'b1}}));
            sum_sat  = sat_next ? '1 : sum_wide[ACC_W-1:0];
        end

        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                acc        <= '0;
                acc_sat    <= 1'b0;
                data_val_o <= 1'b0;
                data_sat_o <= 1'b0;
                data_o     <= '0;
            end else if (en) begin
                data_val_o <= end_word;
                if (vld_t) begin
                    acc     <= sum_sat;
                    acc_sat <= sat_next;
                end else begin
                    acc     <= base_acc;
                    acc_sat <= base_sat;
                end
                if (end_word) begin
                    data_o     <= sum_sat;
                    data_sat_o <= sat_next;
                end else begin
                    data_sat_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: three instances (per-word, per-frame with a
// 16-bit sum, per-frame with a 6-bit saturating sum) share one stimulus
// stream. Each instance has its own valid line so a word is offered to every
// instance until that instance has taken it.
module tb_popcount_stream;

    localparam int W   = 24;
    localparam int LAT = 5;
    localparam int ACCW [3] = '{0, 16, 6};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         arst_ni;
    logic [W-1:0] data;
    logic         last;
    logic         zeros;
    logic         ready_i;
    logic [2:0]   val_v;
    logic [2:0]   rdy_v;
    logic [2:0]   vo_v;
    logic [2:0]   sat_v;
    logic [4:0]   d0;
    logic [15:0]  d1;
    logic [5:0]   d2;
    logic [15:0]  dout [3];

    assign dout[0] = {11'b0, d0};
    assign dout[1] = d1;
    assign dout[2] = {10'b0, d2};

    popcount_stream #(.WIDTH(W), .ACCUMULATE(0)) u_word (
        .clk_i(clk), .arst_ni(arst_ni), .data_i(data), .data_val_i(val_v[0]),
        .data_last_i(last), .cnt_zeros_i(zeros), .data_ready_o(rdy_v[0]),
        .data_o(d0), .data_sat_o(sat_v[0]), .data_val_o(vo_v[0]), .data_ready_i(ready_i));

    popcount_stream #(.WIDTH(W), .ACCUMULATE(1), .ACC_W(16)) u_frame (
        .clk_i(clk), .arst_ni(arst_ni), .data_i(data), .data_val_i(val_v[1]),
        .data_last_i(last), .cnt_zeros_i(1'b0), .data_ready_o(rdy_v[1]),
        .data_o(d1), .data_sat_o(sat_v[1]), .data_val_o(vo_v[1]), .data_ready_i(ready_i));

    popcount_stream #(.WIDTH(W), .ACCUMULATE(1), .ACC_W(6)) u_sat (
        .clk_i(clk), .arst_ni(arst_ni), .data_i(data), .data_val_i(val_v[2]),
        .data_last_i(last), .cnt_zeros_i(1'b0), .data_ready_o(rdy_v[2]),
        .data_o(d2), .data_sat_o(sat_v[2]), .data_val_o(vo_v[2]), .data_ready_i(ready_i));

    typedef struct packed {
        int d;
        int s;
        int cyc;
        int stl;
    } exp_t;

    exp_t exq   [3][$];
    int   obs_d [3][$];
    int   obs_s [3][$];
    int   psum  [3];
    int   stall [3];
    logic hold  [3];
    int   hold_d [3];
    logic hold_s [3];
    int   low0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   force_low = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: count bits of the real word that differ from the "zero" selector
    function automatic int ref_count(input logic [W-1:0] w, input logic z);
        int c;
        c = 0;
        for (int i = 0; i < W; i++) begin
            if (w[i] != z) c++;
        end
        return c;
    endfunction

    // Downstream ready generator
    initial begin
        ready_i = 1'b1;
        forever begin
            @(negedge clk);
            if (force_low > 0) begin
                ready_i = 1'b0;
                force_low--;
            end else begin
                ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor and compare process: runs every cycle, away from the clock edge
    initial begin
        exp_t e;
        int   c;
        int   mx;
        for (int i = 0; i < 3; i++) begin
            psum[i] = 0; stall[i] = 0; hold[i] = 1'b0;
        end
        low0 = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!arst_ni) begin
                for (int i = 0; i < 3; i++) begin
                    exq[i].delete();
                    psum[i] = 0;
                    hold[i] = 1'b0;
                    chk($sformatf("rst_val[%0d]", i), int'(vo_v[i]), 0);
                    chk($sformatf("rst_sat[%0d]", i), int'(sat_v[i]), 0);
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("ready_rule[%0d]", i), int'(rdy_v[i]), int'(!vo_v[i] || ready_i));
                    if (hold[i]) begin
                        chk($sformatf("hold_val[%0d]", i), int'(vo_v[i]), 1);
                        chk($sformatf("hold_data[%0d]", i), int'(dout[i]), hold_d[i]);
                        chk($sformatf("hold_sat[%0d]", i), int'(sat_v[i]), int'(hold_s[i]));
                    end
                    hold[i] = 1'b0;
                    if (vo_v[i]) begin
                        if (ready_i) begin
                            if (exq[i].size() == 0) begin
                                chk($sformatf("spurious_out[%0d]", i), int'(dout[i]), -1);
                            end else begin
                                e = exq[i].pop_front();
                                chk($sformatf("data[%0d]", i), int'(dout[i]), e.d);
                                chk($sformatf("sat[%0d]", i), int'(sat_v[i]), e.s);
                                chk($sformatf("latency[%0d]", i), cyc - e.cyc - (stall[i] - e.stl), LAT);
                                obs_d[i].push_back(int'(dout[i]));
                                obs_s[i].push_back(int'(sat_v[i]));
                            end
                        end else begin
                            hold[i]   = 1'b1;
                            hold_d[i] = int'(dout[i]);
                            hold_s[i] = sat_v[i];
                        end
                    end
                    if (val_v[i] && rdy_v[i]) begin
                        if (i == 0) begin
                            c = ref_count(data, zeros);
                            exq[i].push_back('{d: c, s: 0, cyc: cyc, stl: stall[i]});
                        end else begin
                            psum[i] += ref_count(data, 1'b0);
                            if (last) begin
                                mx = (1 << ACCW[i]) - 1;
                                exq[i].push_back('{d: (psum[i] > mx) ? mx : psum[i],
                                                   s: (psum[i] > mx) ? 1 : 0,
                                                   cyc: cyc, stl: stall[i]});
                                psum[i] = 0;
                            end
                        end
                    end
                    if (!rdy_v[i]) stall[i]++;
                end
                if (!rdy_v[0]) low0++;
            end
        end
    end

    // Offer one word to all three instances until each has accepted it
    task automatic send(input logic [W-1:0] w, input logic l, input logic z);
        logic [2:0] pend;
        logic [2:0] took;
        int         guard;
        pend  = 3'b111;
        guard = 0;
        while (pend != 3'b000 && guard < 200) begin
            @(negedge clk);
            data  = w;
            last  = l;
            zeros = z;
            val_v = pend;
            #1;
            took = pend & rdy_v;
            @(posedge clk);
            #1;
            pend  = pend & ~took;
            val_v = 3'b000;
            guard++;
        end
        chk("send_timeout", int'(pend), 0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exq[0].size() + exq[1].size() + exq[2].size()) > 0 && guard < 500) begin
            @(negedge clk);
            #3;
            guard++;
        end
        chk("drain_timeout", exq[0].size() + exq[1].size() + exq[2].size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 3; i++) begin
            obs_d[i].delete();
            obs_s[i].delete();
        end
    endtask

    function automatic int obs_at(input int i, input int k);
        return (obs_d[i].size() > k) ? obs_d[i][k] : -1;
    endfunction

    function automatic int sat_at(input int i, input int k);
        return (obs_s[i].size() > k) ? obs_s[i][k] : -1;
    endfunction

    initial begin
        logic [W-1:0] w;
        int           sel;
        arst_ni = 1'b0;
        data    = '0;
        last    = 1'b0;
        zeros   = 1'b0;
        val_v   = 3'b000;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data0", int'(d0), 0);
        chk("rst_data1", int'(d1), 0);
        chk("rst_data2", int'(d2), 0);
        @(negedge clk);
        arst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back words, full throughput
        clear_obs();
        send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'h000000, 1'b0, 1'b0);
        send(24'h800001, 1'b1, 1'b0);
        drain();
        chk("b2b_cnt", obs_d[0].size(), 3);
        chk("b2b_w0", obs_at(0, 0), 24);
        chk("b2b_w1", obs_at(0, 1), 0);
        chk("b2b_w2", obs_at(0, 2), 2);
        chk("b2b_frame", obs_at(1, 0), 26);

        // Counting zeros ignores pad bits
        clear_obs();
        send(24'h00000F, 1'b1, 1'b1);
        drain();
        chk("zeros_cnt", obs_at(0, 0), 20);
        chk("zeros_frame", obs_at(1, 0), 4);

        // Frame of three words, then a single-word frame
        clear_obs();
        send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'h0000FF, 1'b0, 1'b0);
        send(24'h000001, 1'b1, 1'b0);
        send(24'h000003, 1'b1, 1'b0);
        drain();
        chk("frame_n", obs_d[1].size(), 2);
        chk("frame_sum", obs_at(1, 0), 33);
        chk("frame_sat", sat_at(1, 0), 0);
        chk("frame1_sum", obs_at(1, 1), 2);
        chk("frame1_sat", sat_at(1, 1), 0);
        chk("frame_sum6", obs_at(2, 0), 33);

        // Saturation of the 6-bit sum
        clear_obs();
        repeat (2) send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'hFFFFFF, 1'b1, 1'b0);
        drain();
        chk("sat_sum", obs_at(2, 0), 63);
        chk("sat_flag", sat_at(2, 0), 1);
        chk("nosat_sum", obs_at(1, 0), 72);
        chk("nosat_flag", sat_at(1, 0), 0);

        // Four-cycle backpressure in the middle of a 10-word stream
        clear_obs();
        low0 = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send(W'(32'h00_1357 * (k + 1)), (k == 9), k[0]);
                end
            end
            begin
                repeat (7) @(posedge clk);
                force_low = 4;
            end
        join
        drain();
        chk("bp_words", obs_d[0].size(), 10);
        chk("bp_ready_low", low0, 4);
        chk("bp_frames", obs_d[1].size(), 1);

        // Reset in the middle of a frame with words in flight
        clear_obs();
        for (int k = 0; k < 5; k++) send(24'hFFFFFF, 1'b0, 1'b0);
        @(negedge clk);
        #4;
        chk("pre_rst_val", int'(vo_v[0]), 1);
        #1;
        arst_ni = 1'b0;
        #1;
        chk("async_val0", int'(vo_v[0]), 0);
        chk("async_val1", int'(vo_v[1]), 0);
        chk("async_data0", int'(d0), 0);
        repeat (3) @(negedge clk);
        arst_ni = 1'b1;
        repeat (2) @(negedge clk);
        clear_obs();
        send(24'h000003, 1'b1, 1'b0);
        drain();
        chk("post_rst_n", obs_d[1].size(), 1);
        chk("post_rst_frame", obs_at(1, 0), 2);
        chk("post_rst_frame6", obs_at(2, 0), 2);
        chk("post_rst_word", obs_at(0, 0), 2);

        // Randomised traffic with random backpressure and gaps
        rand_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       w = 24'hFFFFFF;
                1:       w = 24'h000000;
                default: w = W'($urandom);
            endcase
            send(w, (k == 299) || ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rand_rdy = 1'b0;
        drain();
        chk("end_q0", exq[0].size(), 0);
        chk("end_q1", exq[1].size(), 0);
        chk("end_q2", exq[2].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
